// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and event record for the PS/2 receiver.
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_ev_t;

  localparam int EV_W = $bits(ps2_ev_t);

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead event FIFO; head reads as zero when empty.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [EV_W-1:0] wr_data,
  input  logic            pop,
  output logic [EV_W-1:0] rd_data,
  output logic            full,
  output logic            empty,
  output logic            overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [EV_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [AW:0]     cnt;
  logic            do_push;
  logic            do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign rd_data  = empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wr_data;
  end

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard receiver: sync, framing, parity, E0/F0 prefixes,
// and a buffered key-event queue, all in the system clock domain.
module ps2_rx_controller
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       Clock,
  input  logic       iReset,
  input  logic       ClockTeclado,
  input  logic       i1b,
  input  logic       iRead,
  output logic [7:0] oKey,
  output logic       oBreak,
  output logic       oExtended,
  output logic       oValid,
  output logic       oParityError,
  output logic       oFrameError,
  output logic       oOverflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          clk_s1, clk_s2, clk_s3;
  logic          dat_s1, dat_s2;
  logic          fall;
  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [9:0]    sr, sr_nx;
  logic [TW-1:0] tmo, tmo_nx;
  logic          ext, ext_nx;
  logic          brk, brk_nx;
  logic          push;
  ps2_ev_t       push_ev;
  ps2_ev_t       head;
  logic          par_err;
  logic          frm_err;
  logic          full;
  logic          empty;

  assign fall = clk_s3 & ~clk_s2;

  always_ff @(posedge Clock) begin
    if (iReset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      tmo    <= '0;
      ext    <= 1'b0;
      brk    <= 1'b0;
    end else begin
      clk_s1 <= ClockTeclado;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= i1b;
      dat_s2 <= dat_s1;
      state  <= state_nx;
      cnt    <= cnt_nx;
      sr     <= sr_nx;
      tmo    <= tmo_nx;
      ext    <= ext_nx;
      brk    <= brk_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sr_nx    = sr;
    tmo_nx   = tmo;
    ext_nx   = ext;
    brk_nx   = brk;
    push     = 1'b0;
    push_ev  = '0;
    par_err  = 1'b0;
    frm_err  = 1'b0;
    unique case (state)
      IDLE: begin
        tmo_nx = '0;
        if (fall && !dat_s2) begin
          state_nx = RECV;
          cnt_nx   = 4'd1;
        end
      end
      RECV: begin
        if (fall) begin
          sr_nx  = {dat_s2, sr[9:1]};
          tmo_nx = '0;
          cnt_nx = cnt + 4'd1;
          if (cnt == 4'(PS2_FRAME_BITS - 1)) state_nx = CHECK;
        end else if (tmo == TW'(TIMEOUT_CYCLES)) begin
          frm_err  = 1'b1;
          ext_nx   = 1'b0;
          brk_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          tmo_nx = tmo + 1'b1;
        end
      end
      CHECK: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        // sr = {stop, parity, data[7:0]}
        if (!sr[9]) begin
          frm_err = 1'b1;
          ext_nx  = 1'b0;
          brk_nx  = 1'b0;
        end else if (!(^sr[8:0])) begin
          par_err = 1'b1;
          ext_nx  = 1'b0;
          brk_nx  = 1'b0;
        end else if (sr[7:0] == PS2_EXT) begin
          ext_nx = 1'b1;
        end else if (sr[7:0] == PS2_BREAK) begin
          brk_nx = 1'b1;
        end else begin
          push         = 1'b1;
          push_ev.ext  = ext;
          push_ev.brk  = brk;
          push_ev.code = sr[7:0];
          ext_nx       = 1'b0;
          brk_nx       = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (Clock),
    .rst      (iReset),
    .push     (push),
    .wr_data  (push_ev),
    .pop      (iRead),
    .rd_data  (head),
    .full     (full),
    .empty    (empty),
    .overflow (oOverflow)
  );

  assign oKey         = head.code;
  assign oBreak       = head.brk;
  assign oExtended    = head.ext;
  assign oValid       = ~empty;
  assign oParityError = par_err;
  assign oFrameError  = frm_err;

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Directed bench for ps2_rx_controller with hand-computed key events.
module tb_ps2_rx_controller;

  localparam int HALF = 20;
  localparam int TMO  = 200;

  logic       Clock = 1'b0;
  logic       iReset;
  logic       ClockTeclado;
  logic       i1b;
  logic       iRead;
  logic [7:0] oKey;
  logic       oBreak;
  logic       oExtended;
  logic       oValid;
  logic       oParityError;
  logic       oFrameError;
  logic       oOverflow;

  int errors = 0;
  int checks = 0;
  int n_par  = 0;
  int n_frm  = 0;
  int n_ovf  = 0;

  ps2_rx_controller #(
    .TIMEOUT_CYCLES(TMO),
    .FIFO_DEPTH    (4)
  ) dut (
    .Clock        (Clock),
    .iReset       (iReset),
    .ClockTeclado (ClockTeclado),
    .i1b          (i1b),
    .iRead        (iRead),
    .oKey         (oKey),
    .oBreak       (oBreak),
    .oExtended    (oExtended),
    .oValid       (oValid),
    .oParityError (oParityError),
    .oFrameError  (oFrameError),
    .oOverflow    (oOverflow)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (oParityError) n_par++;
    if (oFrameError)  n_frm++;
    if (oOverflow)    n_ovf++;
  end

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input int nbits, input bit pop_push,
                            input bit lat_chk);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge Clock);
      i1b = f[i];
      repeat (HALF) @(negedge Clock);
      ClockTeclado = 1'b0;
      if (i == 10) begin
        repeat (3) @(negedge Clock);
        if (lat_chk) check("lat_n3", oValid, 0);
        if (pop_push) iRead = 1'b1;
        @(negedge Clock);
        iRead = 1'b0;
        if (lat_chk) check("lat_n4", oValid, 1);
        repeat (HALF - 4) @(negedge Clock);
      end else begin
        repeat (HALF) @(negedge Clock);
      end
      ClockTeclado = 1'b1;
    end
    @(negedge Clock);
    i1b = 1'b1;
    repeat (HALF) @(negedge Clock);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0, 1'b0);
  endtask

  task automatic pop();
    @(negedge Clock);
    iRead = 1'b1;
    @(negedge Clock);
    iRead = 1'b0;
  endtask

  task automatic head(input string tag, input logic [7:0] k,
                      input logic b, input logic e);
    check({tag, "_v"}, oValid, 1);
    check({tag, "_k"}, oKey, k);
    check({tag, "_b"}, oBreak, b);
    check({tag, "_e"}, oExtended, e);
  endtask

  int p0, f0, o0;
  logic [7:0] exp_q [4];

  initial begin
    iReset       = 1'b1;
    ClockTeclado = 1'b1;
    i1b          = 1'b1;
    iRead        = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_v", oValid, 0);
    check("rst_k", oKey, 0);
    check("rst_pe", oParityError, 0);
    check("rst_fe", oFrameError, 0);
    iReset = 1'b0;
    repeat (5) @(negedge Clock);

    // single make code with latency probe
    send_frame(8'h1C, 1'b0, 11, 1'b0, 1'b1);
    head("t1", 8'h1C, 0, 0);
    pop();
    check("t1_empty", oValid, 0);

    // break prefix
    send(8'hF0);
    check("t2_pre", oValid, 0);
    send(8'h1C);
    head("t2", 8'h1C, 1, 0);
    pop();
    check("t2_one", oValid, 0);

    // extended break, then plain make
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    head("t3a", 8'h75, 1, 1);
    pop();
    send(8'h75);
    head("t3b", 8'h75, 0, 0);
    pop();
    check("t3_empty", oValid, 0);

    // parity error clears state, next break event resumes
    p0 = n_par;
    send(8'hE0);
    send_frame(8'h1C, 1'b1, 11, 1'b0, 1'b0);
    check("t4_pe", n_par - p0, 1);
    check("t4_v", oValid, 0);
    send(8'hF0);
    send(8'h1C);
    head("t4", 8'h1C, 1, 0);
    pop();

    // timeout mid-frame after a pending prefix
    f0 = n_frm;
    p0 = n_par;
    send(8'hF0);
    send_frame(8'h1C, 1'b0, 5, 1'b0, 1'b0);
    repeat (2 * TMO) @(negedge Clock);
    check("t5_fe", n_frm - f0, 1);
    check("t5_pe", n_par - p0, 0);
    check("t5_v", oValid, 0);
    send(8'h1C);
    head("t5", 8'h1C, 0, 0);
    pop();

    // reset mid-frame: no error pulse, clean restart
    f0 = n_frm;
    send_frame(8'h1C, 1'b0, 5, 1'b0, 1'b0);
    iReset = 1'b1;
    repeat (3) @(negedge Clock);
    iReset = 1'b0;
    repeat (5) @(negedge Clock);
    check("t6_fe", n_frm - f0, 0);
    send(8'h2E);
    head("t6", 8'h2E, 0, 0);
    pop();

    // overflow: fifth event dropped
    o0 = n_ovf;
    send(8'h16);
    send(8'h1E);
    send(8'h26);
    send(8'h25);
    check("t7_novf", n_ovf - o0, 0);
    send(8'h2E);
    check("t7_ovf", n_ovf - o0, 1);
    exp_q = '{8'h16, 8'h1E, 8'h26, 8'h25};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t7_k%0d", i), oKey, exp_q[i]);
      pop();
    end
    check("t7_empty", oValid, 0);

    // pop coincides with fifth push: both succeed
    o0 = n_ovf;
    send(8'h16);
    send(8'h1E);
    send(8'h26);
    send(8'h25);
    send_frame(8'h2E, 1'b0, 11, 1'b1, 1'b0);
    check("t8_ovf", n_ovf - o0, 0);
    exp_q = '{8'h1E, 8'h26, 8'h25, 8'h2E};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t8_k%0d", i), oKey, exp_q[i]);
      pop();
    end
    check("t8_empty", oValid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
